// File: rtl/cpu5_lsu_ctrl_pkg.sv
// cpu5_lsu_ctrl_pkg
// Shared types and constants for the cpu5 load/store unit: FSM state
// encoding, access size, funct3 codes and the alignment helpers used by
// both the sequencer and the lane/extend logic.
package cpu5_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  localparam int LSU_BE_SIZE = 4;

  // funct3[1:0]: 0 byte, 1 half, 2/3 word. funct3[2] only selects zero-extend.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    if (f3[1])      return SZ_WORD;
    else if (f3[0]) return SZ_HALF;
    else            return SZ_BYTE;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu5_lsu_ctrl_if.sv
// cpu5_lsu_ctrl_if
// Data-bus request/grant/response bundle between the LSU (master) and the
// memory side (slave).
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : request, held until bus_gnt
//   bus_gnt                                  : request accepted this cycle
//   bus_rvalid/bus_rdata                     : read response, full word
interface cpu5_lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/cpu5_lsu_ctrl_align.sv
// cpu5_lsu_align
// Combinational lane logic for the LSU.
//   st_size/st_off/st_wdata -> st_be, st_wdata_rep : store byte enables and
//                                                   lane-replicated data
//   ld_size/ld_zext/ld_off/rdata -> ld_ext         : load lane extract and
//                                                   sign/zero extension
module cpu5_lsu_align
  import cpu5_lsu_ctrl_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  lsu_size_e   ld_size,
  input  logic        ld_zext,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted_next;

  always_comb begin
    case (st_size)
      SZ_BYTE: st_be = 4'b0001 << st_off;
      SZ_HALF: st_be = 4'b0011 << {st_off[1], 1'b0};
      default: st_be = 4'b1111;
    endcase
  end

  // Each lane carries the byte that would land there for any legal offset,
  // so the bus side only needs byte enables to pick the target.
  for (genvar gi = 0; gi < LSU_BE_SIZE; gi++) begin : g_lane
    assign st_wdata_rep[8*gi +: 8] =
      (st_size == SZ_BYTE) ? st_wdata[7:0] :
      (st_size == SZ_HALF) ? st_wdata[8*(gi%2) +: 8] :
                             st_wdata[8*gi +: 8];
  end

  assign shifted_next = rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_size)
      SZ_BYTE: ld_ext = {{24{~ld_zext & shifted_next[7]}}, shifted_next[7:0]};
      SZ_HALF: ld_ext = {{16{~ld_zext & shifted_next[15]}}, shifted_next[15:0]};
      default: ld_ext = shifted_next;
    endcase
  end

endmodule

// File: rtl/cpu5_lsu_ctrl.sv
// cpu5_lsu_ctrl
// Load/store sequencer for the cpu5 MEM stage. Accepts one memory op at a
// time, runs it over the request/grant/response bus, stalls the pipeline
// until it finishes and returns extended load data. Misaligned accesses
// never reach the bus; they raise a one-cycle exception strobe instead.
// Ports:
//   clk, resetn                       : clock, async active-low reset
//   mem_valid, memtoreg, memwrite,
//   funct3, addr, wdata, rd, flush    : MEM-stage op and kill
//   stall                             : hold IF..MEM
//   ld_valid, ld_data, ld_rd          : load writeback (one-cycle strobe)
//   excp_misalign, excp_addr          : misaligned-access strobe
//   bus                               : data bus, master side
module cpu5_lsu_ctrl
  import cpu5_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [4:0]        rd,
  input  logic              flush,
  output logic              stall,
  output logic              ld_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic [4:0]        ld_rd,
  output logic              excp_misalign,
  output logic [ADDR_W-1:0] excp_addr,
  cpu5_lsu_ctrl_if.master   bus
);

  lsu_state_e  state_reg;
  lsu_size_e   size_reg;
  logic        zext_reg;
  logic [1:0]  off_reg;
  logic        kill_reg;

  lsu_size_e   acc_size;
  logic        memop;
  logic        misal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_ext;

  assign acc_size = f3_size(funct3);
  assign memop    = mem_valid & (memtoreg | memwrite) & ~flush;
  assign misal    = is_misaligned(acc_size, addr[1:0]);

  // The accepting IDLE cycle must already stall, so this term stays combinational.
  assign stall = (state_reg == LSU_IDLE) ? memop
               : ((state_reg == LSU_REQ) || (state_reg == LSU_WAIT));

  cpu5_lsu_align u_align (
    .st_size      (acc_size),
    .st_off       (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_reg),
    .ld_zext      (zext_reg),
    .ld_off       (off_reg),
    .rdata        (bus.bus_rdata),
    .ld_ext       (ld_ext)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= LSU_IDLE;
      size_reg      <= SZ_BYTE;
      zext_reg      <= 1'b0;
      off_reg       <= 2'b00;
      kill_reg      <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= '0;
      ld_valid      <= 1'b0;
      ld_data       <= '0;
      ld_rd         <= 5'd0;
      excp_misalign <= 1'b0;
      excp_addr     <= '0;
    end else begin
      ld_valid      <= 1'b0;
      excp_misalign <= 1'b0;
      case (state_reg)
        LSU_IDLE: begin
          if (memop) begin
            if (misal) begin
              excp_misalign <= 1'b1;
              excp_addr     <= addr;
              state_reg     <= LSU_DONE;
            end else begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= memwrite;
              bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus.bus_be    <= st_be;
              bus.bus_wdata <= st_wdata_rep;
              size_reg      <= acc_size;
              zext_reg      <= funct3[2];
              off_reg       <= addr[1:0];
              ld_rd         <= rd;
              kill_reg      <= 1'b0;
              state_reg     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          // Once granted the transaction must finish; a flush only kills
          // the writeback. Before grant the request can simply be withdrawn.
          if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            kill_reg    <= flush;
            if (bus.bus_we) begin
              state_reg <= LSU_DONE;
            end else if (bus.bus_rvalid) begin
              ld_data   <= ld_ext;
              ld_valid  <= ~flush;
              state_reg <= LSU_DONE;
            end else begin
              state_reg <= LSU_WAIT;
            end
          end else if (flush) begin
            bus.bus_req <= 1'b0;
            state_reg   <= LSU_IDLE;
          end
        end
        LSU_WAIT: begin
          if (flush) kill_reg <= 1'b1;
          if (bus.bus_rvalid) begin
            ld_data   <= ld_ext;
            ld_valid  <= ~(kill_reg | flush);
            state_reg <= LSU_DONE;
          end
        end
        default: begin
          state_reg <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu5_lsu_ctrl.sv
module tb_cpu5_lsu_ctrl;
  import cpu5_lsu_ctrl_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int XLEN    = 32;
  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_EXCP  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              mem_valid = 1'b0, memtoreg = 1'b0, memwrite = 1'b0, flush = 1'b0;
  logic [2:0]        funct3 = 3'd0;
  logic [ADDR_W-1:0] addr = '0;
  logic [XLEN-1:0]   wdata = '0;
  logic [4:0]        rd = 5'd0;
  logic              stall, ld_valid, excp_misalign;
  logic [XLEN-1:0]   ld_data;
  logic [4:0]        ld_rd;
  logic [ADDR_W-1:0] excp_addr;

  cpu5_lsu_ctrl_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();

  cpu5_lsu_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .memtoreg(memtoreg),
    .memwrite(memwrite), .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
    .flush(flush), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_rd(ld_rd), .excp_misalign(excp_misalign), .excp_addr(excp_addr),
    .bus(bus.master)
  );

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem_b [64];   // reference model: byte-addressed memory
  logic [31:0] mem_w [16];   // bus slave storage: word-addressed
  int          gnt_cfg = -1, rv_cfg = -1;
  int          req_cnt = 0, rvalid_cnt = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0, last_ld_data = '0;
  logic [3:0]  last_rd_be = '0, last_wr_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic void preload(input int widx, input logic [31:0] v);
    mem_w[widx] = v;
    for (int i = 0; i < 4; i++) mem_b[widx*4 + i] = v[8*i +: 8];
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  // Reference load: gather bytes little-endian, then extend by arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int     sz = size_of(f3);
    longint v = 0;
    for (int i = 0; i < sz; i++) v += longint'(mem_b[(a + i) & 63]) << (8*i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  function automatic void expect_op(input logic [2:0] f3, input logic st, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [4:0] r);
    exp_t e;
    int   sz = size_of(f3);
    e.kind = K_LOAD; e.rd = r; e.data = '0; e.addr = a; e.be = '0;
    if ((a % sz) != 0) begin
      e.kind = K_EXCP;
    end else if (st) begin
      e.kind = K_STORE;
      e.addr = a & ~32'd3;
      e.be   = 4'(((1 << sz) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) e.data[8*i +: 8] = wd[8*(i % sz) +: 8];
      for (int i = 0; i < sz; i++) mem_b[(a + i) & 63] = wd[8*i +: 8];
    end else begin
      e.data = model_load(f3, a);
    end
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [2:0] f3, input logic st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r);
    mem_valid = 1'b1; memtoreg = ~st; memwrite = st;
    funct3 = f3; addr = a; wdata = wd; rd = r;
  endtask

  task automatic undrive();
    mem_valid = 1'b0; memtoreg = 1'b0; memwrite = 1'b0;
  endtask

  // One complete op: expectation pushed, inputs held while stall is high.
  task automatic issue(input logic [2:0] f3, input logic st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r, output int stall_cycles);
    bit ok = 1'b0;
    expect_op(f3, st, a, wd, r);
    @(negedge clk);
    drive(f3, st, a, wd, r);
    stall_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) begin ok = 1'b1; break; end
      stall_cycles++;
      @(negedge clk);
    end
    if (!ok) check("op_timeout", 32'(ok), 32'd1);
    undrive();
  endtask

  // Monitor: pops the scoreboard whenever a writeback or exception strobe appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && (ld_valid || excp_misalign)) begin
        check("one_strobe", 32'(ld_valid & excp_misalign), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: ld_valid=%0b excp=%0b with empty queue", ld_valid, excp_misalign);
        end else begin
          e = exp_q.pop_front();
          if (ld_valid) begin
            check("ld_kind", 32'(K_LOAD), 32'(e.kind));
            check("ld_rd", 32'(ld_rd), 32'(e.rd));
            check("ld_data", ld_data, e.data);
            last_ld_data = ld_data;
            $display("load  addr=0x%08h rd=%0d data=0x%08h", e.addr, ld_rd, ld_data);
          end else begin
            check("excp_kind", 32'(K_EXCP), 32'(e.kind));
            check("excp_addr", excp_addr, e.addr);
            $display("excp  addr=0x%08h", excp_addr);
          end
        end
      end
    end
  end

  // Bus slave: random grant and response latency; checks stores at grant.
  int          s_gd, s_rd;
  logic [31:0] s_a, s_w;
  logic [3:0]  s_b;
  logic        s_we;
  bit          s_alive;
  exp_t        s_e;
  initial begin
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (resetn && bus.bus_req) begin
        req_cnt++;
        s_gd = (gnt_cfg >= 0) ? gnt_cfg : int'($urandom_range(0, 3));
        s_rd = (rv_cfg >= 0) ? rv_cfg : int'($urandom_range(0, 3));
        s_a = bus.bus_addr; s_w = bus.bus_wdata; s_b = bus.bus_be; s_we = bus.bus_we;
        s_alive = 1'b1;
        for (int i = 0; i < s_gd && s_alive; i++) begin
          @(negedge clk);
          if (!resetn || !bus.bus_req) s_alive = 1'b0;
          else begin
            check("hold_addr", bus.bus_addr, s_a);
            check("hold_wdata", bus.bus_wdata, s_w);
            check("hold_be_we", {27'd0, bus.bus_we, bus.bus_be}, {27'd0, s_we, s_b});
          end
        end
        if (s_alive) begin
          bus.bus_gnt = 1'b1;
          if (s_we) begin
            last_wr_addr = bus.bus_addr; last_wr_data = bus.bus_wdata; last_wr_be = bus.bus_be;
            for (int i = 0; i < 4; i++)
              if (bus.bus_be[i]) mem_w[bus.bus_addr[5:2]][8*i +: 8] = bus.bus_wdata[8*i +: 8];
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_store: addr=0x%08h with empty queue", bus.bus_addr);
            end else begin
              s_e = exp_q.pop_front();
              check("st_kind", 32'(K_STORE), 32'(s_e.kind));
              check("st_addr", bus.bus_addr, s_e.addr);
              check("st_be", 32'(bus.bus_be), 32'(s_e.be));
              check("st_wdata", bus.bus_wdata, s_e.data);
              $display("store addr=0x%08h be=%04b data=0x%08h", bus.bus_addr, bus.bus_be, bus.bus_wdata);
            end
          end else begin
            last_rd_addr = bus.bus_addr; last_rd_be = bus.bus_be;
            if (s_rd == 0) begin
              bus.bus_rvalid = 1'b1; bus.bus_rdata = mem_w[s_a[5:2]]; rvalid_cnt++;
            end
          end
          @(negedge clk);
          bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
          if (!resetn) s_alive = 1'b0;
          if (!s_we && s_rd > 0) begin
            for (int i = 1; i < s_rd && s_alive; i++) begin
              @(negedge clk);
              if (!resetn) s_alive = 1'b0;
            end
            if (s_alive && resetn) begin
              bus.bus_rvalid = 1'b1; bus.bus_rdata = mem_w[s_a[5:2]]; rvalid_cnt++;
              @(negedge clk);
              bus.bus_rvalid = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] ld_f3 [5];
  int         sc, r0, c0;
  bit         saw;
  initial begin
    ld_f3[0] = FUNCT3_LB; ld_f3[1] = FUNCT3_LH; ld_f3[2] = FUNCT3_LW;
    ld_f3[3] = FUNCT3_LBU; ld_f3[4] = FUNCT3_LHU;
    for (int w = 0; w < 16; w++) preload(w, $urandom);

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_we", {30'd0, bus.bus_req, bus.bus_we}, 32'd0);
    check("rst_strobes", {30'd0, ld_valid, excp_misalign}, 32'd0);
    check("rst_addr_be", bus.bus_addr | 32'(bus.bus_be), 32'd0);
    check("rst_data", bus.bus_wdata | ld_data | excp_addr | 32'(ld_rd), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // lw 0x104, immediate grant, rvalid one cycle later
    preload(1, 32'h11223344);
    gnt_cfg = 0; rv_cfg = 1;
    issue(FUNCT3_LW, 1'b0, 32'h104, 32'h0, 5'd5, sc);
    check("lw_stall_cycles", 32'(sc), 32'd3);
    check("lw_bus_addr", last_rd_addr, 32'h104);
    check("lw_bus_be", 32'(last_rd_be), 32'hF);
    check("lw_data", last_ld_data, 32'h11223344);

    // lb / lbu at byte 3 of 0x80FFFFFF
    preload(0, 32'h80FFFFFF);
    gnt_cfg = -1; rv_cfg = -1;
    issue(FUNCT3_LB, 1'b0, 32'h203, 32'h0, 5'd6, sc);
    check("lb_data", last_ld_data, 32'hFFFFFF80);
    issue(FUNCT3_LBU, 1'b0, 32'h203, 32'h0, 5'd7, sc);
    check("lbu_data", last_ld_data, 32'h00000080);

    // sh 0x302 with grant held off for three cycles
    gnt_cfg = 3;
    issue(FUNCT3_SH, 1'b1, 32'h302, 32'h0000ABCD, 5'd0, sc);
    check("sh_stall_cycles", 32'(sc), 32'd5);
    check("sh_bus_addr", last_wr_addr, 32'h300);
    check("sh_bus_be", 32'(last_wr_be), 32'hC);
    check("sh_bus_wdata", last_wr_data, 32'hABCDABCD);
    gnt_cfg = -1;

    // misaligned lw 0x106: exception only, no bus request
    r0 = req_cnt;
    issue(FUNCT3_LW, 1'b0, 32'h106, 32'h0, 5'd8, sc);
    check("misal_stall_cycles", 32'(sc), 32'd1);
    repeat (2) @(negedge clk);
    check("misal_no_req", 32'(req_cnt - r0), 32'd0);

    // flush while waiting for grant
    gnt_cfg = 6;
    @(negedge clk); drive(FUNCT3_LW, 1'b0, 32'h108, 32'h0, 5'd4);
    @(negedge clk); flush = 1'b1; #1;
    check("flreq_req_before", 32'(bus.bus_req), 32'd1);
    @(negedge clk); flush = 1'b0; undrive(); #1;
    check("flreq_req_dropped", 32'(bus.bus_req), 32'd0);
    check("flreq_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clk);

    // flush after grant: read completes, writeback suppressed
    gnt_cfg = 0; rv_cfg = 2; c0 = rvalid_cnt; saw = 1'b0;
    @(negedge clk); drive(FUNCT3_LW, 1'b0, 32'h10C, 32'h0, 5'd7);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; undrive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ld_valid) saw = 1'b1;
    end
    check("flgnt_no_ld_valid", 32'(saw), 32'd0);
    check("flgnt_rvalid_seen", 32'(rvalid_cnt - c0), 32'd1);

    // reset while waiting for read data
    gnt_cfg = 0; rv_cfg = 3;
    @(negedge clk); drive(FUNCT3_LW, 1'b0, 32'h104, 32'h0, 5'd3);
    @(negedge clk);
    @(negedge clk); undrive(); resetn = 1'b0; #1;
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_req_we", {30'd0, bus.bus_req, bus.bus_we}, 32'd0);
    check("rstw_strobes", {30'd0, ld_valid, excp_misalign}, 32'd0);
    check("rstw_addr_be", bus.bus_addr | 32'(bus.bus_be), 32'd0);
    check("rstw_data", bus.bus_wdata | ld_data | excp_addr | 32'(ld_rd), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    gnt_cfg = -1; rv_cfg = -1;
    issue(FUNCT3_LW, 1'b0, 32'h104, 32'h0, 5'd9, sc);
    check("rstw_lw_after", last_ld_data, model_load(FUNCT3_LW, 32'h104));

    // randomized mix of loads and stores
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0)
        issue(3'($urandom_range(0, 2)), 1'b1, ra, $urandom, 5'd0, sc);
      else
        issue(ld_f3[$urandom_range(0, 4)], 1'b0, ra, 32'h0, 5'($urandom_range(1, 31)), sc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
